// File: rtl/mem_ldst_ctrl_if.sv
// Request/response handshake and RAM port bundle for mem_ldst_ctrl.
// Optional build macro LDST_BP_EN adds the resp_ready back-pressure signal.
interface mem_ldst_ctrl_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 10,
    parameter int unsigned LEN_W  = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [LEN_W-1:0]  req_len;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              resp_last;
`ifdef LDST_BP_EN
    logic              resp_ready;
`endif
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [1:0]        mem_ldst_en;
    logic [DATA_W-1:0] mem_rdata;

    // Controller side
    modport slave (
`ifdef LDST_BP_EN
        input  resp_ready,
`endif
        input  req_valid, req_op, req_addr, req_wdata, req_len, mem_rdata,
        output req_ready, resp_valid, resp_data, resp_last,
        output mem_addr, mem_wdata, mem_ldst_en
    );

    // CPU datapath / RAM side
    modport master (
`ifdef LDST_BP_EN
        output resp_ready,
`endif
        output req_valid, req_op, req_addr, req_wdata, req_len, mem_rdata,
        input  req_ready, resp_valid, resp_data, resp_last,
        input  mem_addr, mem_wdata, mem_ldst_en
    );
endinterface

// File: rtl/mem_ldst_ctrl.sv
// Load/store initiator for the data RAM: single/burst loads streamed back one
// beat per clock, burst stores filled with a constant word and acknowledged.
// Optional build macro LDST_BP_EN adds response back-pressure (resp_ready).
module mem_ldst_ctrl #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 10,
    parameter int unsigned LEN_W  = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_ldst_ctrl_if.slave bus,
    output logic           busy
);
    localparam int unsigned CNT_W    = LEN_W + 1;
    localparam int unsigned MAX_BEAT = 1 << LEN_W;
    localparam logic [1:0]  OP_LOAD  = 2'd2;
    localparam logic [1:0]  OP_STORE = 2'd3;
    localparam logic [1:0]  EN_IDLE  = 2'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_STORE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [1:0]         en_q, en_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  resp_data_q, resp_data_d;
    logic               resp_valid_q, resp_valid_d;
    logic               resp_last_q, resp_last_d;
    logic               req_ready_q, req_ready_d;
    logic               busy_q, busy_d;

    logic               accept_c;
    logic               advance_c;
    logic               hold_resp_c;
    logic               last_beat_c;

    assign accept_c    = bus.req_valid && req_ready_q;
    assign last_beat_c = (cnt_q == CNT_W'(1));

`ifdef LDST_BP_EN
    // A pending response blocks a new load beat and keeps an ack on the bus
    assign advance_c   = !resp_valid_q || bus.resp_ready;
    assign hold_resp_c = resp_valid_q && !bus.resp_ready;
`else
    assign advance_c   = 1'b1;
    assign hold_resp_c = 1'b0;
`endif

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            en_q         <= EN_IDLE;
            cnt_q        <= '0;
            resp_data_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_last_q  <= 1'b0;
            req_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            en_q         <= en_d;
            cnt_q        <= cnt_d;
            resp_data_q  <= resp_data_d;
            resp_valid_q <= resp_valid_d;
            resp_last_q  <= resp_last_d;
            req_ready_q  <= req_ready_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c && bus.req_op == OP_LOAD) begin
                    state_d = ST_LOAD;
                end else if (accept_c && bus.req_op == OP_STORE) begin
                    state_d = ST_STORE;
                end
            end
            ST_LOAD: begin
                if (advance_c && last_beat_c) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STORE: begin
                if (last_beat_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the datapath and registered outputs
    always_comb begin
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        en_d         = en_q;
        cnt_d        = cnt_q;
        resp_data_d  = resp_data_q;
        resp_valid_d = resp_valid_q;
        resp_last_d  = resp_last_q;
        case (state_q)
            ST_IDLE: begin
                if (!hold_resp_c) begin
                    resp_valid_d = 1'b0;
                    resp_last_d  = 1'b0;
                end
                if (accept_c && bus.req_op[1]) begin
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    en_d    = bus.req_op;
                    cnt_d   = (bus.req_len == '0) ? CNT_W'(MAX_BEAT) : CNT_W'(bus.req_len);
                end
            end
            ST_LOAD: begin
                if (advance_c) begin
                    resp_data_d  = bus.mem_rdata;
                    resp_valid_d = 1'b1;
                    resp_last_d  = last_beat_c;
                    addr_d       = addr_q + ADDR_W'(1);
                    cnt_d        = cnt_q - CNT_W'(1);
                    if (last_beat_c) begin
                        en_d = EN_IDLE;
                    end
                end
            end
            ST_STORE: begin
                addr_d       = addr_q + ADDR_W'(1);
                cnt_d        = cnt_q - CNT_W'(1);
                resp_valid_d = 1'b0;
                resp_last_d  = 1'b0;
                if (last_beat_c) begin
                    en_d         = EN_IDLE;
                    resp_valid_d = 1'b1;
                    resp_last_d  = 1'b1;
                    resp_data_d  = DATA_W'(addr_q + ADDR_W'(1));
                end
            end
            default: begin
                en_d         = EN_IDLE;
                resp_valid_d = 1'b0;
                resp_last_d  = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
`ifdef LDST_BP_EN
        req_ready_d = (state_d == ST_IDLE) && !resp_valid_d;
`else
        req_ready_d = (state_d == ST_IDLE);
`endif
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_data   = resp_data_q;
    assign bus.resp_last   = resp_last_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.mem_ldst_en = en_q;
    assign busy            = busy_q;
endmodule
